map_region_writer: RTL and testbench
====================================

Name: map_region_writer

Overview:
- Write-side companion to the pixel-to-map-address reader.
- Fills a clipped rectangular region of the 70x50 map memory with a constant word, one write per permitted cycle.
- Sits between game logic (region requests) and the write port of the map BRAM.
- Writes are gated by a permit input so they occur only when the video reader is not using the memory (e.g. during blanking).

Parameters:
- MAP_W, 70, map width in words; row stride for addressing.
- MAP_H, 50, map height in rows.
- AW, 12, address width; must satisfy MAP_W*MAP_H <= 2^AW.
- DW, 8, data word width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- x0  in  7  region left column.
- y0  in  6  region top row.
- w  in  7  region width in words.
- h  in  6  region height in rows.
- value  in  DW  fill word.
- wr_allow  in  1  write permit; writes occur only while high.
- busy  out  1  high from request acceptance until done.
- done  out  1  one-cycle completion pulse.
- we  out  1  map write enable.
- waddr  out  AW  map write address = row*MAP_W + col.
- wdata  out  DW  map write data.

Behaviour:
- One clock, synchronous active-low reset. Setup uses only clk and reset_n.
- All outputs are registered.

Reset:
- reset_n low at a clk edge forces state IDLE and sets busy=0, done=0, we=0, waddr=0, wdata=0.
- Reset mid-operation aborts the fill. No further writes occur.

States: IDLE, CLIP, RUN, DONE.
- IDLE:
  - start=1 latches x0, y0, w, h and value, sets busy=1, and moves to CLIP.
  - start while busy (any state other than IDLE) is ignored.
- CLIP (1 cycle):
  - Computes x_end = min(x0+w, MAP_W) and y_end = min(y0+h, MAP_H). Widths are extended to 8 bits so there is no overflow.
  - If x0>=MAP_W, y0>=MAP_H, w==0 or h==0, the area is empty: go to DONE with no writes.
  - Otherwise set col=x0, row=y0, row_base=y0*MAP_W and go to RUN.
  - row_base is formed by repeated add or a constant multiply. Inside RUN it is updated only by adding MAP_W; there is no per-write multiplier.
- RUN:
  - At each edge with wr_allow=1: register we=1, waddr=row_base+col, wdata=value.
  - Then advance the pointer:
    - If col==x_end-1: col=x0, row+=1, row_base+=MAP_W.
    - Otherwise col+=1.
  - Write ordering is row-major, left to right, top to bottom.
  - At an edge with wr_allow=0: we=0, the pointer holds, and waddr/wdata hold their last values.
  - The write issued at row==y_end-1 and col==x_end-1 is the last; the next state is DONE.
- DONE (1 cycle):
  - we=0, done=1, busy=0; return to IDLE.
  - A start sampled in this cycle is ignored.
  - start may be accepted in IDLE on the following edge.

Latency and counts:
- With wr_allow held high, the first we=1 appears 2 cycles after start is accepted.
- done rises 1 cycle after the last we.
- Total writes = (x_end-x0)*(y_end-y0), each address written exactly once.
- waddr never reaches MAP_W*MAP_H or above.
- The input fields x0, y0, w, h and value may change after acceptance without effect.

Test Plan:
- Full fill: x0=0, y0=0, w=70, h=50, value=8'hA5, wr_allow=1 → 3500 writes; waddr runs 0..3499 consecutively, wdata=8'hA5 on each; busy high for 3502 cycles; done single-cycle one cycle after waddr=3499.
- Corner clip: x0=68, y0=48, w=5, h=5 → exactly 4 writes at waddr 3428, 3429, 3498, 3499; no address ≥3500.
- Empty region: x0=70 (also w=0, and separately h=0) → no we at any time; done pulses 2 cycles after start; busy high for those cycles only.
- Stall: x0=10, y0=2, w=3, h=2, wr_allow toggling 1/0 each cycle → we only on allowed edges; address sequence is 150, 151, 152, 220, 221, 222, unchanged by stalls.
- Start while busy: second start mid-fill with different value → ignored; the original region and value complete. A start in the DONE cycle is also ignored; a start on the next IDLE cycle is accepted.
- Reset mid-op: reset_n low for 1 cycle after the 5th write of a full fill → the next cycle has we=0, busy=0, done=0, waddr=0; no writes follow until a new start.

Source files
------------

// File: rtl/map_region_writer.sv
// map_region_writer: fills a clipped rectangle of the map memory with a constant word
module map_region_writer #(
    parameter int MAP_W = 70,
    parameter int MAP_H = 50,
    parameter int AW    = 12,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [6:0]    x0,
    input  logic [5:0]    y0,
    input  logic [6:0]    w,
    input  logic [5:0]    h,
    input  logic [DW-1:0] value,
    input  logic          wr_allow,
    output logic          busy,
    output logic          done,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata
);
    typedef enum logic [1:0] {IDLE, CLIP, RUN, DONE} state_t;

    state_t        state;
    logic [6:0]    x0_q, w_q, col;
    logic [5:0]    y0_q, h_q, row;
    logic [DW-1:0] value_q;
    logic [7:0]    x_end, y_end, x_sum, y_sum;
    logic [AW-1:0] row_base;
    logic          empty, col_last, row_last;

    // Region bounds widened to 8 bits so x0+w and y0+h cannot wrap; end-of-row/region flags
    always_comb begin
        x_sum    = {1'b0, x0_q} + {1'b0, w_q};
        y_sum    = {2'b0, y0_q} + {2'b0, h_q};
        empty    = ({1'b0, x0_q} >= 8'(MAP_W)) || ({2'b0, y0_q} >= 8'(MAP_H)) || (w_q == 7'd0) || (h_q == 6'd0);
        col_last = {1'b0, col} == x_end - 8'd1;
        row_last = {2'b0, row} == y_end - 8'd1;
    end

    // Control FSM: latch request, clip once, then walk the region row-major one write per permitted edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    x0_q    <= x0;
                    y0_q    <= y0;
                    w_q     <= w;
                    h_q     <= h;
                    value_q <= value;
                    busy    <= 1'b1;
                    state   <= CLIP;
                end
                CLIP: begin
                    x_end    <= (x_sum > 8'(MAP_W)) ? 8'(MAP_W) : x_sum;
                    y_end    <= (y_sum > 8'(MAP_H)) ? 8'(MAP_H) : y_sum;
                    col      <= x0_q;
                    row      <= y0_q;
                    row_base <= AW'(y0_q) * AW'(MAP_W);
                    state    <= empty ? DONE : RUN;
                end
                RUN: if (wr_allow) begin
                    we    <= 1'b1;
                    waddr <= row_base + AW'(col);
                    wdata <= value_q;
                    if (col_last) begin
                        col      <= x0_q;
                        row      <= row + 6'd1;
                        row_base <= row_base + AW'(MAP_W);
                        if (row_last) state <= DONE;
                    end else begin
                        col <= col + 7'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_map_region_writer.sv
// tb_map_region_writer: randomized and directed region fills checked against a per-cycle reference model
module tb_map_region_writer;
    localparam int MAP_W = 70;
    localparam int MAP_H = 50;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  x0 = '0;
    logic [5:0]  y0 = '0;
    logic [6:0]  w = '0;
    logic [5:0]  h = '0;
    logic [7:0]  value = '0;
    logic        wr_allow = 1'b0;
    logic        busy, done, we;
    logic [11:0] waddr;
    logic [7:0]  wdata;

    int vectors = 0;
    int miscompares = 0;

    map_region_writer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
        .value(value), .wr_allow(wr_allow), .busy(busy), .done(done), .we(we),
        .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Must be called at a negedge; returns at the negedge after the done pulse with start low.
    task automatic run(input int ax0, input int ay0, input int aw, input int ah,
                       input logic [7:0] av, input int mode, input bit extra_starts);
        int   q[$];
        int   xe, ye, rem, done_edge, k, last_addr;
        bit   wrote;
        logic allow_k, exp_we;
        xe = (ax0 + aw < MAP_W) ? ax0 + aw : MAP_W;
        ye = (ay0 + ah < MAP_H) ? ay0 + ah : MAP_H;
        for (int r = ay0; r < ye; r++)
            for (int c = ax0; c < xe; c++)
                q.push_back(r * MAP_W + c);
        x0 = 7'(ax0); y0 = 6'(ay0); w = 7'(aw); h = 6'(ah); value = av;
        start = 1'b1;
        wr_allow = pick(mode, 0);
        rem = q.size();
        done_edge = (rem == 0) ? 2 : -1;
        wrote = 1'b0;
        last_addr = 0;
        for (k = 0; k <= 8000; k++) begin
            allow_k = wr_allow;
            @(posedge clk);
            @(negedge clk);
            exp_we = (k >= 2) && (rem > 0) && allow_k;
            chk("we", we, exp_we);
            if (exp_we) begin
                chk("waddr", waddr, q[0]);
                chk("wdata", wdata, av);
                last_addr = q.pop_front();
                rem--;
                wrote = 1'b1;
                if (rem == 0) done_edge = k + 1;
            end else if (wrote) begin
                chk("waddr_hold", waddr, last_addr);
            end
            chk("done", done, k == done_edge);
            chk("busy", busy, done_edge < 0 || k < done_edge);
            if (k == done_edge) break;
            start = extra_starts && (k == 3 || k + 1 == done_edge);
            x0 = 7'($urandom); y0 = 6'($urandom); w = 7'($urandom); h = 6'($urandom);
            value = ~av;
            wr_allow = pick(mode, k + 1);
        end
        chk("finish_edge", k, done_edge);
        start = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run(0, 0, 70, 50, 8'hA5, 0, 1'b0);
        run(68, 48, 5, 5, 8'h3C, 0, 1'b0);
        run(70, 3, 4, 4, 8'h11, 0, 1'b0);
        run(5, 3, 0, 4, 8'h22, 0, 1'b0);
        run(5, 3, 4, 0, 8'h33, 0, 1'b0);
        run(10, 2, 3, 2, 8'h5A, 1, 1'b0);
        run(20, 10, 6, 4, 8'hC3, 0, 1'b1);
        run(1, 45, 8, 9, 8'h7E, 2, 1'b1);
        for (int i = 0; i < 10; i++)
            run($urandom_range(0, 75), $urandom_range(0, 55), $urandom_range(0, 12),
                $urandom_range(0, 6), 8'($urandom), 2, 1'($urandom_range(0, 1)));

        x0 = 7'd0; y0 = 6'd0; w = 7'd70; h = 6'd50; value = 8'h99;
        wr_allow = 1'b1;
        start = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (we) n++;
        end
        chk("pre_reset_writes", n, 5);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_we", we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_waddr", waddr, 0);
        chk("abort_wdata", wdata, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_abort_we", we, 0);
            chk("post_abort_busy", busy, 0);
        end
        run(30, 20, 5, 3, 8'hE7, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
